// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset/lock supervisor.
package pll_seq_pkg;

    localparam int PLL_SEQ_RST_CYCLES    = 16;
    localparam int PLL_SEQ_STABLE_CYCLES = 1024;
    localparam int PLL_SEQ_LOCK_TIMEOUT  = 65536;
    localparam int PLL_SEQ_MAX_RETRIES   = 7;

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    typedef enum logic [2:0] {
        ST_RESET_PLL = S_RESET_PLL,
        ST_WAIT_LOCK = S_WAIT_LOCK,
        ST_STABLE    = S_STABLE,
        ST_RUN       = S_RUN,
        ST_FAULT     = S_FAULT
    } pll_seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit (or bundled) inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset and lock supervisor: resets the PLL, qualifies lock, releases sys reset.
// Optional retry/fault handling on lock timeout is enabled by PLL_RETRY_EN.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = PLL_SEQ_RST_CYCLES,
    parameter int STABLE_CYCLES = PLL_SEQ_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT  = PLL_SEQ_LOCK_TIMEOUT,
    parameter int MAX_RETRIES   = PLL_SEQ_MAX_RETRIES
) (
    input  logic       clk_74a_i,
    input  logic       reset_n_i,
    input  logic       pll_locked_i,
    input  logic       pll_reset_req_i,
    output logic       pll_rst_o,
    output logic       sys_reset_n_o,
    output logic       lock_lost_o,
    output logic       fault_o,
    output logic [2:0] retry_count_o
);

    localparam int CNT_W = $clog2(max_int(max_int(RST_CYCLES, STABLE_CYCLES),
                                          max_int(LOCK_TIMEOUT, MAX_RETRIES))) + 1;

    logic             locked_s;
    pll_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pll_rst_q, sys_rst_n_q;
    logic             lost_q, lost_d;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i  (clk_74a_i),
        .rst_ni (reset_n_i),
        .d_i    (pll_locked_i),
        .q_o    (locked_s)
    );

`ifdef PLL_RETRY_EN
    logic [2:0] retry_q, retry_d;
    logic [3:0] retry_inc;
    logic       fault_q;
`endif

    // One shared counter: every state entry clears it, so each state sees a fresh count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        lost_d  = lost_q;
`ifdef PLL_RETRY_EN
        retry_d   = retry_q;
        retry_inc = {1'b0, retry_q} + 4'd1;
`endif
        if (pll_reset_req_i && (state_q != ST_FAULT)) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
`ifdef PLL_RETRY_EN
                    if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        retry_d = retry_inc[3] ? 3'd7 : retry_inc[2:0];
                        state_d = (retry_inc <= 4'(MAX_RETRIES)) ? ST_RESET_PLL : ST_FAULT;
                        cnt_d   = '0;
                    end else if (locked_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end
`else
                    cnt_d = '0;
                    if (locked_s) state_d = ST_STABLE;
`endif
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                    // Lock drop: hold the system in reset but leave the PLL running.
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        lost_d  = 1'b1;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_74a_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= (state_d == ST_RESET_PLL);
            sys_rst_n_q <= (state_d == ST_RUN);
            lost_q      <= lost_d;
        end
    end

`ifdef PLL_RETRY_EN
    always_ff @(posedge clk_74a_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            retry_q <= '0;
            fault_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign retry_count_o = retry_q;
    assign fault_o       = fault_q;
`else
    assign retry_count_o = 3'd0;
    assign fault_o       = 1'b0;
`endif

    assign pll_rst_o     = pll_rst_q;
    assign sys_reset_n_o = sys_rst_n_q;
    assign lock_lost_o   = lost_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: edge-count expectations derived from the sequencing rules.
module tb_pll_reset_seq;

    localparam int RST  = 16;
    localparam int STB  = 1024;
    localparam int TO   = 64;
    localparam int MAXR = 2;
    localparam int SYNC = 2;
`ifdef PLL_RETRY_EN
    localparam int LDMAX = 40;
    localparam int CLEAN_D = 30;
`else
    localparam int LDMAX = 300;
    localparam int CLEAN_D = 100;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       req = 1'b0;
    logic       pll_rst, sys_n, lock_lost, fault;
    logic [2:0] retry;
    logic       rst_seen = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .RST_CYCLES(RST), .STABLE_CYCLES(STB), .LOCK_TIMEOUT(TO), .MAX_RETRIES(MAXR)
    ) dut (
        .clk_74a_i       (clk),
        .reset_n_i       (reset_n),
        .pll_locked_i    (pll_locked),
        .pll_reset_req_i (req),
        .pll_rst_o       (pll_rst),
        .sys_reset_n_o   (sys_n),
        .lock_lost_o     (lock_lost),
        .fault_o         (fault),
        .retry_count_o   (retry)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (pll_rst) rst_seen = 1'b1;
    endtask

    task automatic wait_sys(input int budget, output int n);
        n = 0;
        while (!sys_n && n < budget) begin step(); n++; end
    endtask

    task automatic wait_rst_fall(input int budget, output int n);
        n = 0;
        while (pll_rst && n < budget) begin step(); n++; end
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (sys_n !== 1'b0) begin failures++; $display("FAIL reset_sys_n: got %b expected 0", sys_n); end
        checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (retry !== 3'd0) begin failures++; $display("FAIL reset_retry: got %0d expected 0", retry); end
        repeat (3) step();
        reset_n = 1'b1;
        wait_rst_fall(RST + 10, n);
        checks++; if (n !== RST) begin failures++; $display("FAIL rst_release: got %0d edges expected %0d", n, RST); end
    endtask

    task automatic test_clean_lock();
        int n;
        rst_seen = 1'b0;
        repeat (CLEAN_D) step();
        pll_locked = 1'b1;
        wait_sys(SYNC + 1 + STB + 20, n);
        checks++; if (n !== SYNC + 1 + STB) begin failures++; $display("FAIL clean_release: got %0d edges expected %0d", n, SYNC + 1 + STB); end
        checks++; if (retry !== 3'd0) begin failures++; $display("FAIL clean_retry: got %0d expected 0", retry); end
        checks++; if (rst_seen !== 1'b0) begin failures++; $display("FAIL clean_no_rst: got %b expected 0", rst_seen); end
    endtask

    task automatic test_glitchy_lock();
        int n, h, hi;
        for (int it = 0; it < 2; it++) begin
            pll_locked = 1'b0;
            pulse_req();
            wait_rst_fall(RST + 10, n);
            h  = $urandom_range(0, LDMAX);
            hi = (it == 0) ? 500 : $urandom_range(5, 1000);
            repeat (h) step();
            pll_locked = 1'b1;
            repeat (hi) step();
            pll_locked = 1'b0;
            step();
            pll_locked = 1'b1;
            wait_sys(SYNC + 1 + STB + 20, n);
            checks++; if (n !== SYNC + 1 + STB) begin failures++; $display("FAIL glitch_release[%0d] hi=%0d: got %0d edges expected %0d", it, hi, n, SYNC + 1 + STB); end
        end
    endtask

    task automatic test_lock_loss();
        int n, h;
        checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL loss_pre: got %b expected 0", lock_lost); end
        rst_seen = 1'b0;
        pll_locked = 1'b0;
        n = 0;
        while (sys_n && n < 10) begin step(); n++; end
        checks++; if (n !== SYNC + 1) begin failures++; $display("FAIL loss_latency: got %0d edges expected %0d", n, SYNC + 1); end
        checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL loss_flag: got %b expected 1", lock_lost); end
        h = $urandom_range(1, LDMAX);
        repeat (h) step();
        pll_locked = 1'b1;
        wait_sys(SYNC + 1 + STB + 20, n);
        checks++; if (n !== SYNC + 1 + STB) begin failures++; $display("FAIL loss_relock: got %0d edges expected %0d", n, SYNC + 1 + STB); end
        checks++; if (rst_seen !== 1'b0) begin failures++; $display("FAIL loss_no_rst: got %b expected 0", rst_seen); end
        checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL loss_sticky: got %b expected 1", lock_lost); end
    endtask

    task automatic test_soft_req();
        int n;
        pulse_req();
        checks++; if ({pll_rst, sys_n} !== 2'b10) begin failures++; $display("FAIL req_entry: got rst=%b sys_n=%b expected rst=1 sys_n=0", pll_rst, sys_n); end
        wait_rst_fall(RST + 10, n);
        checks++; if (n !== RST) begin failures++; $display("FAIL req_rst_width: got %0d expected %0d", n, RST); end
        checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL req_lock_lost: got %b expected 1", lock_lost); end
        wait_sys(1 + STB + 20, n);
        checks++; if (n !== 1 + STB) begin failures++; $display("FAIL req_release: got %0d edges expected %0d", n, 1 + STB); end
    endtask

    task automatic test_async_reset();
        int n, k;
        pulse_req();
        wait_rst_fall(RST + 10, n);
        k = $urandom_range(10, 500);
        repeat (k) step();
        #3 reset_n = 1'b0;
        #1;
        checks++; if ({pll_rst, sys_n, lock_lost, fault, retry} !== 7'b1000000) begin
            failures++;
            $display("FAIL async_reset: got rst=%b sys_n=%b lost=%b fault=%b retry=%0d expected 1 0 0 0 0", pll_rst, sys_n, lock_lost, fault, retry);
        end
        repeat (2) step();
        reset_n = 1'b1;
        wait_rst_fall(RST + 10, n);
        checks++; if (n !== RST) begin failures++; $display("FAIL async_rst_release: got %0d expected %0d", n, RST); end
        wait_sys(1 + STB + 20, n);
        checks++; if (n !== 1 + STB) begin failures++; $display("FAIL async_release: got %0d edges expected %0d", n, 1 + STB); end
    endtask

`ifdef PLL_RETRY_EN
    task automatic test_retry_exhaust();
        int   rise_e, pulses, fault_e, retry_pre, retry_post, budget, exp_post;
        logic prev;
        budget   = (MAXR + 1) * (RST + TO) + 50;
        exp_post = (MAXR + 1 > 7) ? 7 : MAXR + 1;
        pll_locked = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        repeat (2) step();
        reset_n    = 1'b1;
        prev       = 1'b1;
        rise_e     = 0;
        pulses     = 1;
        fault_e    = -1;
        retry_pre  = -1;
        retry_post = -1;
        for (int e = 1; e <= budget && fault_e < 0; e++) begin
            step();
            if (pll_rst && !prev) begin pulses++; rise_e = e; end
            if (!pll_rst && prev) begin
                checks++; if (e - rise_e !== RST) begin failures++; $display("FAIL retry_pulse_width[%0d]: got %0d expected %0d", pulses, e - rise_e, RST); end
            end
            if (fault && fault_e < 0) begin fault_e = e; retry_post = int'(retry); end
            else if (!fault) retry_pre = int'(retry);
            prev = pll_rst;
        end
        checks++; if (pulses !== MAXR + 1) begin failures++; $display("FAIL retry_pulses: got %0d expected %0d", pulses, MAXR + 1); end
        checks++; if (fault_e !== (MAXR + 1) * (RST + TO)) begin failures++; $display("FAIL fault_edge: got %0d expected %0d", fault_e, (MAXR + 1) * (RST + TO)); end
        checks++; if (retry_pre !== MAXR) begin failures++; $display("FAIL retry_before_fault: got %0d expected %0d", retry_pre, MAXR); end
        checks++; if (retry_post !== exp_post) begin failures++; $display("FAIL retry_at_fault: got %0d expected %0d", retry_post, exp_post); end
        rst_seen = 1'b0;
        pulse_req();
        repeat (5) step();
        checks++; if ({rst_seen, sys_n, fault} !== 3'b001) begin
            failures++;
            $display("FAIL fault_ignores_req: got rst_seen=%b sys_n=%b fault=%b expected 0 0 1", rst_seen, sys_n, fault);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_lock();
        test_glitchy_lock();
        test_lock_loss();
        test_soft_req();
        test_async_reset();
`ifdef PLL_RETRY_EN
        test_retry_exhaust();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset and lock supervisor for the memory/core PLL. Runs on the 74.25 MHz reference clock, drives the PLL's active-high reset, synchronizes and qualifies its `locked` output, and releases a single system reset once lock has been continuously stable. It sits directly upstream of the PLL (feeds `rst`) and consumes its `locked`. All PLL-clocked logic derives its reset from `sys_reset_n`.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt; must be ≥ 4.
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release.
- `LOCK_TIMEOUT`, 65536: WAIT_LOCK cycles before a retry; only used with retry enabled.
- `MAX_RETRIES`, 7: retries before FAULT; 1..7.

- `clk_74a` in 1: reference clock, same net as the PLL `refclk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock, asynchronous to `clk_74a`.
- `pll_reset_req` in 1: single-cycle request to re-run the full sequence.
- `pll_rst` out 1: PLL reset, active high.
- `sys_reset_n` out 1: system reset, active low, registered.
- `lock_lost` out 1: sticky flag, set when lock drops in RUN.
- `fault` out 1: retries exhausted.
- `retry_count` out 3: number of retries so far, saturating.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`.
- The FSM has five states: RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT.
- **RESET_PLL**
  - `pll_rst`=1 and `sys_reset_n`=0.
  - The counter runs for RST_CYCLES cycles, then the FSM enters WAIT_LOCK with `pll_rst`=0.
  - RST_CYCLES ≥ 4 guarantees the synchronizer has flushed stale lock.
- **WAIT_LOCK**
  - `locked_s`=1 → STABLE, with the stable counter cleared.
  - Timeout counter reaches LOCK_TIMEOUT-1 → retry handling (see Configuration).
- **STABLE**
  - `locked_s`=0 → WAIT_LOCK; the timeout counter restarts at 0.
  - Stable counter reaches STABLE_CYCLES-1 → RUN.
- **RUN**
  - `sys_reset_n`=1.
  - `locked_s`=0 → WAIT_LOCK, `sys_reset_n`=0 on the same edge, `lock_lost`=1.
  - The PLL is not re-reset on a lock drop in RUN.
- **FAULT**
  - `pll_rst`=0, `sys_reset_n`=0, `fault`=1.
  - Terminal until `reset_n`; `pll_reset_req` is ignored.
- **`pll_reset_req`** (any state except FAULT)
  - → RESET_PLL with counters cleared.
  - `retry_count` and `lock_lost` are unchanged; it does not count as a retry.
- **Priority on the same edge:** `reset_n` > `pll_reset_req` > timeout > lock events.
- **Counters**
  - Width is $clog2 of the largest parameter, plus 1.
  - Each counter clears on every state entry.

## Timing
- **Reset values:** `pll_rst`=1, `sys_reset_n`=0, `lock_lost`=0, `fault`=0, `retry_count`=0; the FSM starts in RESET_PLL and the synchronizer flops are 0.
- **`pll_rst` release:** falls on edge RST_CYCLES after the first edge with `reset_n` high.
- **`pll_locked` → `locked_s`:** 2 cycles.
- **Release latency:** `sys_reset_n` rises STABLE_CYCLES edges after the first WAIT_LOCK edge that samples `locked_s`=1.
- **Lock loss in RUN:** `pll_locked` falling → `sys_reset_n` low within 3 edges.
- **Mid-sequence reset:** `reset_n` asserted during any state forces the reset values immediately, asynchronously.
- **Output registration:** all outputs are registered; there are no combinational paths from inputs.

## Configuration
- Macro: `PLL_RETRY_EN`.
- **With it defined**
  - A WAIT_LOCK timeout increments `retry_count`.
  - If the new count is ≤ MAX_RETRIES, the FSM goes to RESET_PLL; otherwise it goes to FAULT.
- **Without it**
  - There is no timeout counter and WAIT_LOCK waits indefinitely.
  - `retry_count` is tied to 0 and `fault` is tied to 0; FAULT is unreachable.

## Structure
- **Shared package** `pll_seq_pkg`:
  - state enum `pll_seq_state_t`;
  - default constants `PLL_SEQ_RST_CYCLES`, `PLL_SEQ_STABLE_CYCLES`, `PLL_SEQ_LOCK_TIMEOUT`, `PLL_SEQ_MAX_RETRIES`.
- **Sub-module** `sync_2ff`: a generic 2-flop synchronizer with asynchronous active-low reset, used for `pll_locked`.

## Test plan
- **Clean lock:** defaults, `pll_locked` rises 100 cycles after `pll_rst` falls → `sys_reset_n` high exactly 1024 edges after the first `locked_s`=1 sample in WAIT_LOCK; `retry_count`=0.
- **Glitchy lock:** `pll_locked` high for 500 cycles, low for 1, then high → stable count restarts; release comes 1024 edges after the second qualified high.
- **Lock loss in RUN:** drop `pll_locked` in RUN → `sys_reset_n`=0 within 3 edges and `lock_lost`=1; `pll_rst` stays 0; relock releases again after 1024 cycles.
- **Retry exhaustion** (`PLL_RETRY_EN`, LOCK_TIMEOUT=64, MAX_RETRIES=2):
  - stimulus: `pll_locked` held 0;
  - response: `pll_rst` pulses 3 times, each 16 cycles wide; `retry_count`=2; the next timeout sets `fault`=1.
- **Soft request:** `pll_reset_req` pulsed in RUN → `pll_rst` high for 16 cycles and `sys_reset_n`=0; `lock_lost` unchanged.
- **Async reset mid-sequence:** `reset_n` asserted mid-STABLE → all outputs at reset values without a clock edge.
